// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ requesters:
// grants, latches the winner's byte/parity setup, strobes tx_start and tracks tx_busy.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_parity_en,
    input  logic [N_REQ-1:0]   req_even_parity,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic               tx_start,
    output logic [7:0]         data_in,
    output logic               parity_en,
    output logic               even_parity,
    input  logic               tx_busy
);
    localparam int PW = $clog2(N_REQ);
    localparam int SW = PW + 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, FRAME} state_t;
    state_t state, state_nxt;

    logic [N_REQ-1:0][7:0] req_byte;
    logic [PW-1:0]         ptr, win, cand;
    logic [SW-1:0]         sum;
    logic [N_REQ-1:0]      win_oh;
    logic                  hit, grant, timeout;
    logic [CW-1:0]         cnt;

    assign req_byte = req_data;
    assign grant    = (state == IDLE) && !tx_busy && hit;
    assign timeout  = (cnt == CNT_LAST);

    // Search starts one past the last winner and wraps; first requester found wins.
    always_comb begin
        win  = ptr;
        hit  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N_REQ))
                sum = sum - SW'(N_REQ);
            cand = sum[PW-1:0];
            if (!hit && req[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)
                    state_nxt = FRAME;
                else if (timeout)
                    state_nxt = IDLE;
            end
            FRAME:     if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // gnt is one-hot of the winner for the whole frame, so it doubles as the done/err mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= PW'(N_REQ - 1);
            cnt         <= '0;
            gnt         <= '0;
            done        <= '0;
            err         <= '0;
            tx_start    <= 1'b0;
            data_in     <= 8'h00;
            parity_en   <= 1'b0;
            even_parity <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= '0;
            err      <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt         <= win_oh;
                        ptr         <= win;
                        data_in     <= req_byte[win];
                        parity_en   <= req_parity_en[win];
                        even_parity <= req_even_parity[win];
                        tx_start    <= 1'b1;
                    end
                end
                START: cnt <= '0;
                WAIT_BUSY: begin
                    if (cnt != CNT_MAX)
                        cnt <= cnt + CW'(1);
                    if (!tx_busy && timeout) begin
                        err <= gnt;
                        gnt <= '0;
                    end
                end
                FRAME: begin
                    if (!tx_busy) begin
                        done <= gnt;
                        gnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations, then random
// requesters and a random transmitter, all checked every cycle against a frame-level model.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int BT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*8-1:0] req_data = '0;
    logic [NR-1:0] req_parity_en = '0;
    logic [NR-1:0] req_even_parity = '0;
    logic [NR-1:0] gnt, done, err;
    logic tx_start, parity_en, even_parity;
    logic [7:0] data_in;
    logic tx_busy;
    logic tx_busy_m = 1'b0;
    logic tx_force = 1'b0;
    logic tx_force_val = 1'b0;
    int fix_dly = 2;
    int fix_len = 3;
    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    assign tx_busy = tx_force ? tx_force_val : tx_busy_m;
    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .req_parity_en(req_parity_en), .req_even_parity(req_even_parity),
        .gnt(gnt), .done(done), .err(err), .tx_start(tx_start), .data_in(data_in),
        .parity_en(parity_en), .even_parity(even_parity), .tx_busy(tx_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 'h%0h, want 'h%0h", nm, $time, act, exp);
        end
    endtask

    // Transmitter: busy rises fix_dly cycles after the tx_start cycle (0 = random, -1 = never)
    // and stays up fix_len cycles (0 = random).
    initial begin
        int cyc, rise_at, fall_at, d;
        cyc = 0; rise_at = -1; fall_at = -1; d = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst_n) begin
                tx_busy_m = 1'b0; rise_at = -1; fall_at = -1;
            end else begin
                if (tx_start) begin
                    d = fix_dly;
                    if (d == 0) begin
                        case ($urandom_range(0, 9))
                            0: d = BT;
                            1: d = BT + 1;
                            2: d = 3 * BT;
                            default: d = int'($urandom_range(1, 5));
                        endcase
                    end
                    rise_at = (d < 0) ? -1 : cyc + d;
                end
                if (cyc == rise_at) begin
                    tx_busy_m = 1'b1;
                    fall_at = cyc + ((fix_len > 0) ? fix_len : int'($urandom_range(1, 8)));
                    rise_at = -1;
                end else if (cyc == fall_at) begin
                    tx_busy_m = 1'b0;
                    fall_at = -1;
                end
            end
        end
    end

    // Frame-level model: owner = granted requester (-1 when free), t = cycles since the grant.
    int m_own, m_ptr, m_t;
    bit m_seen;
    logic [NR-1:0] e_gnt, e_done, e_err;
    logic e_start, e_pe, e_ep;
    logic [7:0] e_data;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_own = -1; m_ptr = NR - 1; m_t = 0; m_seen = 1'b0;
            e_gnt = '0; e_done = '0; e_err = '0; e_start = 1'b0;
            e_data = '0; e_pe = 1'b0; e_ep = 1'b0;
        end else begin
            e_done = '0; e_err = '0; e_start = 1'b0;
            if (m_own < 0) begin
                if (!tx_busy) begin
                    for (int j = 1; j <= NR; j++)
                        if (m_own < 0 && req[(m_ptr + j) % NR]) m_own = (m_ptr + j) % NR;
                    if (m_own >= 0) begin
                        m_ptr = m_own;
                        e_data = req_data[8*m_own +: 8];
                        e_pe = req_parity_en[m_own];
                        e_ep = req_even_parity[m_own];
                        e_start = 1'b1;
                        m_t = 0;
                        m_seen = 1'b0;
                    end
                end
            end else begin
                if (m_t >= 1) begin
                    if (m_seen && !tx_busy) begin
                        e_done[m_own] = 1'b1; m_own = -1;
                    end else if (!m_seen && tx_busy) begin
                        m_seen = 1'b1;
                    end else if (!m_seen && m_t == BT) begin
                        e_err[m_own] = 1'b1; m_own = -1;
                    end
                end
                m_t++;
            end
            e_gnt = '0;
            if (m_own >= 0) e_gnt[m_own] = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            chk("gnt", gnt, e_gnt);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("tx_start", tx_start, e_start);
            chk("latched", {parity_en, even_parity, data_in}, {e_pe, e_ep, e_data});
        end
    end

    task automatic wait_resp(input int w);
        int n = 0;
        while (done == 0 && err == 0 && n < 200) begin @(negedge clk); n++; end
        chk("resp_done", done, 1 << w);
        chk("resp_gnt_clear", gnt, 0);
        req[w] = 1'b0;
    endtask

    task automatic serve(input int w, input bit imm);
        int n = 0;
        @(negedge clk);
        while (gnt == 0 && n < 60) begin @(negedge clk); n++; end
        if (imm) chk("b2b_gap", n, 0);
        chk("rr_grant", gnt, 1 << w);
        wait_resp(w);
    endtask

    initial begin
        int n;
        @(negedge clk);
        cmp_on = 1'b1;
        chk("rst_gnt", gnt, 0);
        chk("rst_out", {done, err, tx_start, parity_en, even_parity, data_in}, 0);
        #2 rst_n = 1'b1;

        // single request
        @(negedge clk);
        req_data[23:16] = 8'hA5; req_parity_en[2] = 1'b1; req_even_parity[2] = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        chk("t1_gnt", gnt, 4'b0100);
        chk("t1_data", data_in, 8'hA5);
        chk("t1_par", {parity_en, even_parity}, 2'b11);
        chk("t1_start", tx_start, 1);
        @(negedge clk);
        chk("t1_start_once", tx_start, 0);
        wait_resp(2);
        @(negedge clk);
        chk("t1_done_once", done, 0);

        // timeout, then the next grant goes to winner+1
        fix_dly = -1;
        req = 4'b0100;
        @(negedge clk);
        chk("to_start", tx_start, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (err == 0 && done == 0 && n < 40);
        chk("to_cycles", n, BT + 1);
        chk("to_err", err, 4'b0100);
        chk("to_nodone", done, 0);
        req = 4'b1000;
        fix_dly = 2;
        @(negedge clk);
        chk("to_next", gnt, 4'b1000);
        wait_resp(3);

        // all requesting, back-to-back
        @(negedge clk);
        req = 4'b1111;
        serve(0, 0); serve(1, 1); serve(2, 1); serve(3, 1);

        // fairness
        @(negedge clk);
        req = 4'b0010;
        serve(1, 0);
        @(negedge clk);
        req = 4'b1011;
        serve(3, 0); serve(0, 1); serve(1, 1);
        @(negedge clk);
        req = 4'b0011;
        serve(0, 0); serve(1, 1);

        // external busy holds off the grant
        fix_dly = -1;
        @(negedge clk);
        tx_force = 1'b1; tx_force_val = 1'b1;
        req = 4'b0001;
        repeat (4) begin
            @(negedge clk);
            chk("xb_nognt", gnt, 0);
            chk("xb_nostart", tx_start, 0);
        end
        tx_force_val = 1'b0;
        @(negedge clk);
        chk("xb_gnt", gnt, 4'b0001);
        chk("xb_start", tx_start, 1);
        @(negedge clk);
        tx_force_val = 1'b1;
        repeat (3) @(negedge clk);
        tx_force_val = 1'b0;
        wait_resp(0);
        tx_force = 1'b0;

        // reset in the middle of a frame
        fix_dly = 1; fix_len = 20;
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("rm_gnt", gnt, 4'b0010);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_gnt_clr", gnt, 0);
        chk("rm_start_clr", tx_start, 0);
        chk("rm_data_clr", data_in, 0);
        chk("rm_nodone", done, 0);
        req = 4'b1001;
        fix_len = 3;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rm_first", gnt, 4'b0001);
        req[3] = 1'b0;
        wait_resp(0);

        // random traffic
        fix_dly = 0; fix_len = 0;
        repeat (3000) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (done[i] || err[i])
                    req[i] = 1'b0;
                else if (!req[i]) begin
                    if ($urandom_range(0, 4) == 0) req[i] = 1'b1;
                end else if (!gnt[i] && $urandom_range(0, 19) == 0)
                    req[i] = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_parity_en[i] = 1'($urandom);
                    req_even_parity[i] = 1'($urandom);
                end
            end
        end
        req = '0;
        repeat (80) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
